// File: rtl/odd_pipe_quadword_shifter.sv
// Quadword shift-left / rotate-left unit for the odd pipe: bit and byte forms,
// register-count and immediate variants, with a valid-tracked, stallable, flushable pipe.
module odd_pipe_quadword_shifter #(
   parameter int QW_WIDTH      = 128,
   parameter int STAGES        = 4,
   parameter int RT_ADDR_WIDTH = 7
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [2:0]               op_sel,
   input  logic [QW_WIDTH-1:0]      ra_input,
   input  logic [QW_WIDTH-1:0]      rb_input,
   input  logic [6:0]               I7_input,
   input  logic [RT_ADDR_WIDTH-1:0] rt_address_input,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [QW_WIDTH-1:0]      rt_value_output,
   output logic [RT_ADDR_WIDTH-1:0] rt_address_output,
   output logic                     wrt_en_output,
   output logic                     busy
);

   localparam int NB = QW_WIDTH / 8;
   localparam int BW = $clog2(NB) + 1;

   logic                     rotate;
   logic                     byte_form;
   logic                     imm_form;
   logic [2:0]               bit_cnt;
   logic [BW-1:0]            rb_byte_cnt;
   logic [BW-1:0]            i7_byte_cnt;
   logic [BW-1:0]            byte_cnt;
   logic [BW-1:0]            rot_bytes;
   logic [31:0]              shamt;
   logic [QW_WIDTH-1:0]      shl;
   logic [QW_WIDTH-1:0]      rol;
   logic [QW_WIDTH-1:0]      result;
   logic                     accept;
   logic                     unused_cnt_bits;

   logic [STAGES-1:0]        vld_q;
   logic [QW_WIDTH-1:0]      val_q  [STAGES];
   logic [RT_ADDR_WIDTH-1:0] addr_q [STAGES];

   // op_sel encodes {rotate, byte granularity, immediate count}
   assign rotate    = op_sel[2];
   assign byte_form = op_sel[1];
   assign imm_form  = op_sel[0];

   // Big-endian numbering: preferred-slot bit 31 sits at vector bit QW_WIDTH-32.
   assign bit_cnt     = imm_form ? I7_input[2:0] : rb_input[QW_WIDTH-32 +: 3];
   assign rb_byte_cnt = rb_input[QW_WIDTH-32 +: BW];

   generate
      if (BW <= 7) begin : g_i7_narrow
         assign i7_byte_cnt = I7_input[BW-1:0];
      end else begin : g_i7_wide
         assign i7_byte_cnt = {{(BW-7){1'b0}}, I7_input};
      end
   endgenerate

   assign byte_cnt  = imm_form ? i7_byte_cnt : rb_byte_cnt;
   assign rot_bytes = byte_cnt % BW'(NB);

   assign unused_cnt_bits = ^{rb_input, I7_input};

   always_comb begin
      shamt = 32'(bit_cnt);
      if (byte_form) begin
         shamt = rotate ? (32'(rot_bytes) << 3) : (32'(byte_cnt) << 3);
      end
      shl = ra_input << shamt;
      // A zero rotate shifts right by the full width, which contributes nothing.
      rol = shl | (ra_input >> (32'(QW_WIDTH) - shamt));
      if (rotate) begin
         result = rol;
      end else if (byte_form && (32'(byte_cnt) >= 32'(NB))) begin
         result = '0;
      end else begin
         result = shl;
      end
   end

   assign accept = in_valid & ~stall & ~flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            val_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         if (flush) begin
            vld_q <= '0;
         end else if (!stall) begin
            vld_q[0] <= accept;
            for (int i = 1; i < STAGES; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
         // Data keeps moving under flush; the cleared valid bits make it inert.
         if (!stall) begin
            if (accept) begin
               val_q[0]  <= result;
               addr_q[0] <= rt_address_input;
            end
            for (int i = 1; i < STAGES; i++) begin
               val_q[i]  <= val_q[i-1];
               addr_q[i] <= addr_q[i-1];
            end
         end
      end
   end

   assign out_valid         = vld_q[STAGES-1];
   assign wrt_en_output     = vld_q[STAGES-1];
   assign rt_value_output   = val_q[STAGES-1];
   assign rt_address_output = addr_q[STAGES-1];
   assign busy              = |vld_q;

endmodule

// File: tb/tb_odd_pipe_quadword_shifter.sv
// Scoreboard bench for odd_pipe_quadword_shifter: a 128-bit/4-stage instance and a
// 64-bit/1-stage instance, directed vectors with hand-computed results.
module tb_odd_pipe_quadword_shifter;

   localparam int STG = 4;

   typedef struct {
      logic [127:0] val;
      logic [6:0]   addr;
      int           due;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [2:0]   op_sel;
   logic [127:0] ra_input;
   logic [127:0] rb_input;
   logic [6:0]   I7_input;
   logic [6:0]   rt_address_input;
   logic         stall;
   logic         flush;
   logic         out_valid;
   logic [127:0] rt_value_output;
   logic [6:0]   rt_address_output;
   logic         wrt_en_output;
   logic         busy;

   logic         in_valid64;
   logic [2:0]   op64;
   logic [63:0]  ra64;
   logic [63:0]  rb64;
   logic [6:0]   i7_64;
   logic [6:0]   addr64;
   logic         out_valid64;
   logic [63:0]  val_out64;
   logic [6:0]   addr_out64;
   logic         wrt_en64;
   logic         busy64;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   hold_cnt = 0;
   logic last_stall = 1'b0;
   exp_t q[$];
   exp_t q64[$];
   exp_t held;
   exp_t held64;

   odd_pipe_quadword_shifter #(.QW_WIDTH(128), .STAGES(STG), .RT_ADDR_WIDTH(7)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .op_sel(op_sel),
      .ra_input(ra_input), .rb_input(rb_input), .I7_input(I7_input),
      .rt_address_input(rt_address_input), .stall(stall), .flush(flush),
      .out_valid(out_valid), .rt_value_output(rt_value_output),
      .rt_address_output(rt_address_output), .wrt_en_output(wrt_en_output), .busy(busy)
   );

   odd_pipe_quadword_shifter #(.QW_WIDTH(64), .STAGES(1), .RT_ADDR_WIDTH(7)) dut64 (
      .clock(clock), .reset(reset), .in_valid(in_valid64), .op_sel(op64),
      .ra_input(ra64), .rb_input(rb64), .I7_input(i7_64),
      .rt_address_input(addr64), .stall(1'b0), .flush(1'b0),
      .out_valid(out_valid64), .rt_value_output(val_out64),
      .rt_address_output(addr_out64), .wrt_en_output(wrt_en64), .busy(busy64)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc        <= cyc + 1;
      last_stall <= stall & ~flush;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      chk("wrt_en_eq_valid", 128'(wrt_en_output), 128'(out_valid));
      if (out_valid === 1'b1) begin
         if (last_stall) begin
            chk("held_value", rt_value_output, held.val);
            chk("held_addr", 128'(rt_address_output), 128'(held.addr));
            hold_cnt++;
         end else if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: actual addr=%h value=%h required no output",
                     rt_address_output, rt_value_output);
         end else begin
            held = q.pop_front();
            chk("result_value", rt_value_output, held.val);
            chk("result_addr", 128'(rt_address_output), 128'(held.addr));
            if (held.due >= 0) chk_int("latency", cyc, held.due);
         end
      end
   end

   always @(negedge clock) begin
      if (out_valid64 === 1'b1) begin
         if (q64.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write64: actual value=%h required no output", val_out64);
         end else begin
            held64 = q64.pop_front();
            chk("result64_value", 128'(val_out64), held64.val);
            chk("result64_addr", 128'(addr_out64), 128'(held64.addr));
            chk_int("latency64", cyc, held64.due);
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [127:0] ra, input logic [127:0] rb,
                        input logic [6:0] i7, input logic [6:0] addr,
                        input logic [127:0] expv, input bit lat);
      exp_t e;
      op_sel = op; ra_input = ra; rb_input = rb; I7_input = i7;
      rt_address_input = addr; in_valid = 1'b1;
      e.val = expv; e.addr = addr; e.due = lat ? cyc + STG : -1;
      q.push_back(e);
      @(posedge clock); #1;
   endtask

   task automatic drive64(input logic [2:0] op, input logic [63:0] ra, input logic [63:0] rb,
                          input logic [6:0] addr, input logic [63:0] expv);
      exp_t e;
      op64 = op; ra64 = ra; rb64 = rb; i7_64 = 7'd0; addr64 = addr; in_valid64 = 1'b1;
      e.val = 128'(expv); e.addr = addr; e.due = cyc + 1;
      q64.push_back(e);
      @(posedge clock); #1;
      in_valid64 = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; op_sel = '0; ra_input = '0; rb_input = '0;
      I7_input = '0; rt_address_input = '0; stall = 1'b0; flush = 1'b0;
      in_valid64 = 1'b0; op64 = '0; ra64 = '0; rb64 = '0; i7_64 = '0; addr64 = '0;
      #12;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_value", rt_value_output, 128'(0));
      chk("rst_addr", 128'(rt_address_output), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_valid64", 128'(out_valid64), 128'(0));
      @(posedge clock); #1;
      reset = 1'b0;

      // single ops issued back to back, each with a latency check
      drive(3'd0, 128'd20, {32'd3, 96'd0}, 7'd0, 7'd10, 128'd160, 1);
      drive(3'd3, 128'd15, '0, 7'd5, 7'd11,
            128'h0000_0000_0000_0000_0000_0F00_0000_0000, 1);
      drive(3'd2, 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, {32'd16, 96'd0},
            7'd0, 7'd12, 128'd0, 1);
      drive(3'd6, 128'hFF00_0000_0000_0000_0000_0000_0000_0000, {32'd1, 96'd0},
            7'd0, 7'd13, 128'h0000_0000_0000_0000_0000_0000_0000_00FF, 1);
      drive(3'd5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, 7'd8, 7'd14,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1);
      drive(3'd4, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
            {32'hABCD_EF01, {96{1'b1}}}, 7'h7F, 7'd15, 128'd3, 1);
      drive(3'd1, 128'd1, {128{1'b1}}, 7'h7A, 7'd16, 128'd4, 1);
      drive(3'd7, 128'hAB00_0000_0000_0000_0000_0000_0000_00CD, '0, 7'd17, 7'd17,
            128'h0000_0000_0000_0000_0000_0000_0000_CDAB, 1);
      drive(3'd2, 128'd1, {32'hFFFF_FFE2, 96'd0}, 7'd0, 7'd18, 128'h1_0000, 1);
      idle(8);

      // four ops, then a 3-cycle stall with the first one at the output
      hold_cnt = 0;
      drive(3'd1, 128'd3, '0, 7'd1, 7'd20, 128'd6, 1);
      drive(3'd1, 128'd3, '0, 7'd2, 7'd21, 128'd12, 0);
      drive(3'd1, 128'd3, '0, 7'd3, 7'd22, 128'd24, 0);
      drive(3'd1, 128'd3, '0, 7'd4, 7'd23, 128'd48, 0);
      in_valid = 1'b0;
      stall = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      stall = 1'b0;
      idle(6);
      chk_int("stall_hold_cycles", hold_cnt, 3);

      // flush during stall with three ops in flight plus one presented with the flush
      drive(3'd0, 128'd1, {32'd1, 96'd0}, 7'd0, 7'd30, 128'd2, 0);
      drive(3'd0, 128'd1, {32'd2, 96'd0}, 7'd0, 7'd31, 128'd4, 0);
      drive(3'd0, 128'd1, {32'd3, 96'd0}, 7'd0, 7'd32, 128'd8, 0);
      in_valid = 1'b0;
      stall = 1'b1;
      @(posedge clock); #1;
      flush = 1'b1; in_valid = 1'b1; op_sel = 3'd1; ra_input = 128'd5; I7_input = 7'd1;
      rt_address_input = 7'd33;
      @(posedge clock); #1;
      q.delete();
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_busy", 128'(busy), 128'(0));
      idle(8);

      // asynchronous reset in mid-cycle with two ops in flight
      drive(3'd1, 128'd7, '0, 7'd1, 7'd40, 128'd14, 0);
      drive(3'd1, 128'd7, '0, 7'd2, 7'd41, 128'd28, 0);
      in_valid = 1'b0;
      @(posedge clock);
      #3;
      chk("pre_reset_busy", 128'(busy), 128'(1));
      reset = 1'b1;
      #1;
      chk("areset_valid", 128'(out_valid), 128'(0));
      chk("areset_value", rt_value_output, 128'(0));
      chk("areset_addr", 128'(rt_address_output), 128'(0));
      chk("areset_busy", 128'(busy), 128'(0));
      chk("areset_wrt_en", 128'(wrt_en_output), 128'(0));
      q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      idle(6);
      drive(3'd6, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, {32'd2, 96'd0}, 7'd0, 7'd42,
            128'h0304_0506_0708_090A_0B0C_0D0E_0F10_0102, 1);
      idle(6);

      // 64-bit single-stage instance
      drive64(3'd6, 64'h1122_3344_5566_7788, {32'd9, 32'd0}, 7'd50, 64'h2233_4455_6677_8811);
      drive64(3'd2, 64'h1122_3344_5566_7788, {32'd8, 32'd0}, 7'd51, 64'd0);
      drive64(3'd2, 64'h1122_3344_5566_7788, {32'd3, 32'd0}, 7'd52, 64'h4455_6677_8800_0000);
      @(posedge clock); #1;

      for (int i = 0; i < 30 && (q.size() != 0 || q64.size() != 0); i++) @(posedge clock);
      #1;
      chk_int("drain_q", q.size(), 0);
      chk_int("drain_q64", q64.size(), 0);
      chk("final_busy", 128'(busy), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
